pipe_track: RTL and testbench

Datapath and handshake responder for the pipe controller FSM. Consumes the controller's command strobes (move, reset position, shift window, speed up, score) and returns its status inputs (`Pipe_Wait`, `Pipe_Gone`, `Rnd_Ready`). Holds pipe X position, the move-rate divider, the random gap window, and the score. Sits between the pipe FSM and the VGA renderer / score display.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/lfsr16.sv | 34 +++
 rtl/pipe_track.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_track.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: constants and types shared by the pipe datapath blocks.
//   - Screen geometry and gap limits (defaults for pipe_track parameters)
//   - Move divider defaults
//   - LFSR seed, tap mask and single-step helper
//   - Gap FSM state encoding
package pipe_pkg;

   // Screen geometry
   localparam int unsigned SCREEN_W_DEF = 640;
   localparam int unsigned PIPE_W_DEF   = 64;

   // Gap limits (inclusive range for the gap top)
   localparam int unsigned GAP_MIN_DEF  = 48;
   localparam int unsigned GAP_MAX_DEF  = 300;

   // Move divider, in cycles per pixel
   localparam int unsigned DIV_INIT_DEF = 400000;
   localparam int unsigned DIV_STEP_DEF = 20000;
   localparam int unsigned DIV_MIN_DEF  = 100000;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Gap FSM states
   typedef enum logic [0:0] {
      GAP_READY  = 1'b0,
      GAP_SEARCH = 1'b1
   } gap_state_e;

   // One LFSR step: shift left, feedback is the XOR of the tapped bits
   function automatic logic [15:0] lfsr16_next(input logic [15:0] state);
      logic fb;
      fb = ^(state & LFSR_TAPS);
      return {state[14:0], fb};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, advancing every cycle.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, loads SEED
//   state_o : current 16-bit LFSR state (registered)
module lfsr16
   import pipe_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [15:0] state_o
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   // Next LFSR state
   always_comb begin
      state_d = lfsr16_next(state_q);
   end

   // LFSR state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/pipe_track.sv
// pipe_track: datapath and handshake responder for the pipe controller FSM.
// Holds the pipe X position, the move-rate divider, the random gap window and
// the score, and returns the controller's status inputs.
//   iClk, iRst        : clock, synchronous active-high reset
//   iPipe_Pos_Move    : strobe, step pipe left by 1 px and restart interval
//   iPipe_Pos_Rst     : strobe, respawn pipe at right edge (beats Move)
//   iWindow_Shift     : strobe, request a new random gap (ignored mid-search)
//   iPipe_Speed_Inc   : strobe, shorten move interval down to DIV_MIN
//   iScore_Inc        : strobe, saturating score increment
//   oPipe_Wait        : move interval still running
//   oPipe_Gone        : pipe fully off-screen (X == 0)
//   oRnd_Ready        : oGap_Y holds a committed value
//   oPipe_X           : pipe right edge
//   oGap_Y            : gap top Y
//   oScore            : current score
module pipe_track
   import pipe_pkg::*;
#(
   parameter int unsigned SCREEN_W = SCREEN_W_DEF,
   parameter int unsigned PIPE_W   = PIPE_W_DEF,
   parameter int unsigned X_W      = 10,
   parameter int unsigned Y_W      = 9,
   parameter int unsigned GAP_MIN  = GAP_MIN_DEF,
   parameter int unsigned GAP_MAX  = GAP_MAX_DEF,
   parameter int unsigned DIV_W    = 20,
   parameter int unsigned DIV_INIT = DIV_INIT_DEF,
   parameter int unsigned DIV_STEP = DIV_STEP_DEF,
   parameter int unsigned DIV_MIN  = DIV_MIN_DEF,
   parameter int unsigned SCORE_W  = 10
) (
   input  logic               iClk,
   input  logic               iRst,
   input  logic               iPipe_Pos_Move,
   input  logic               iPipe_Pos_Rst,
   input  logic               iWindow_Shift,
   input  logic               iPipe_Speed_Inc,
   input  logic               iScore_Inc,
   output logic               oPipe_Wait,
   output logic               oPipe_Gone,
   output logic               oRnd_Ready,
   output logic [X_W-1:0]     oPipe_X,
   output logic [Y_W-1:0]     oGap_Y,
   output logic [SCORE_W-1:0] oScore
);

   localparam logic [X_W-1:0]     X_START    = X_W'(SCREEN_W + PIPE_W);
   localparam logic [X_W-1:0]     X_ZERO     = X_W'(0);
   localparam logic [X_W-1:0]     X_ONE      = X_W'(1);
   localparam logic [Y_W-1:0]     GAP_MID    = Y_W'((GAP_MIN + GAP_MAX) / 2);
   localparam logic [Y_W-1:0]     GAP_LO     = Y_W'(GAP_MIN);
   localparam logic [Y_W-1:0]     GAP_HI     = Y_W'(GAP_MAX);
   localparam logic [DIV_W-1:0]   DIV_INIT_C = DIV_W'(DIV_INIT);
   localparam logic [DIV_W-1:0]   DIV_STEP_C = DIV_W'(DIV_STEP);
   localparam logic [DIV_W-1:0]   DIV_MIN_C  = DIV_W'(DIV_MIN);
   localparam logic [DIV_W-1:0]   DIV_ZERO   = DIV_W'(0);
   localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
   localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

   logic [X_W-1:0]     pipe_x_q,   pipe_x_d;
   logic [DIV_W-1:0]   div_cnt_q,  div_cnt_d;
   logic [DIV_W-1:0]   div_load_q, div_load_d;
   logic [SCORE_W-1:0] score_q,    score_d;
   logic               wait_q;
   logic               gone_q;

   logic [DIV_W-1:0]   div_sub_s;
   logic [DIV_W-1:0]   div_faster_s;

   gap_state_e         gap_state_q;
   logic               ready_q;
   logic [Y_W-1:0]     gap_y_q;

   logic [15:0]        lfsr_s;
   logic [Y_W-1:0]     sample_s;
   logic               sample_ok_s;
   logic               lfsr_unused_s;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk_i   (iClk),
      .rst_i   (iRst),
      .state_o (lfsr_s)
   );

   assign sample_s      = lfsr_s[Y_W-1:0];
   assign lfsr_unused_s = ^lfsr_s[15:Y_W];

   // Candidate gap value is accepted only inside the inclusive legal range
   always_comb begin
      sample_ok_s = (sample_s >= GAP_LO) && (sample_s <= GAP_HI);
   end

   // Faster reload value; the underflow guard comes before the floor compare
   always_comb begin
      div_sub_s = div_load_q - DIV_STEP_C;
      if ((div_load_q >= DIV_STEP_C) && (div_sub_s >= DIV_MIN_C)) begin
         div_faster_s = div_sub_s;
      end else begin
         div_faster_s = DIV_MIN_C;
      end
   end

   // Next state for position, divider, reload value and score
   always_comb begin
      pipe_x_d   = pipe_x_q;
      div_cnt_d  = div_cnt_q;
      div_load_d = div_load_q;
      score_d    = score_q;

      // Reload uses the current rDivLoad, so a same-cycle speed-up only
      // affects the following reload
      if (iPipe_Pos_Rst) begin
         pipe_x_d  = X_START;
         div_cnt_d = div_load_q;
      end else if (iPipe_Pos_Move) begin
         if (pipe_x_q != X_ZERO) begin
            pipe_x_d = pipe_x_q - X_ONE;
         end else begin
            pipe_x_d = pipe_x_q;
         end
         div_cnt_d = div_load_q;
      end else if (div_cnt_q != DIV_ZERO) begin
         div_cnt_d = div_cnt_q - DIV_ONE;
      end else begin
         div_cnt_d = div_cnt_q;
      end

      if (iPipe_Speed_Inc) begin
         div_load_d = div_faster_s;
      end else begin
         div_load_d = div_load_q;
      end

      if (iScore_Inc && !(&score_q)) begin
         score_d = score_q + SCORE_ONE;
      end else begin
         score_d = score_q;
      end
   end

   // Datapath registers; status flags are registered from next-state values
   always_ff @(posedge iClk) begin
      if (iRst) begin
         pipe_x_q   <= X_START;
         div_cnt_q  <= DIV_INIT_C;
         div_load_q <= DIV_INIT_C;
         score_q    <= '0;
         wait_q     <= (DIV_INIT_C != DIV_ZERO);
         gone_q     <= 1'b0;
      end else begin
         pipe_x_q   <= pipe_x_d;
         div_cnt_q  <= div_cnt_d;
         div_load_q <= div_load_d;
         score_q    <= score_d;
         wait_q     <= (div_cnt_d != DIV_ZERO);
         gone_q     <= (pipe_x_d == X_ZERO);
      end
   end

   // Gap FSM: wait for a shift request, then hunt for an in-range sample
   always_ff @(posedge iClk) begin
      if (iRst) begin
         gap_state_q <= GAP_READY;
         ready_q     <= 1'b1;
         gap_y_q     <= GAP_MID;
      end else begin
         case (gap_state_q)
            GAP_READY: begin
               if (iWindow_Shift) begin
                  gap_state_q <= GAP_SEARCH;
                  ready_q     <= 1'b0;
               end else begin
                  gap_state_q <= GAP_READY;
                  ready_q     <= 1'b1;
               end
            end
            GAP_SEARCH: begin
               // Further shift requests are ignored until a commit
               if (sample_ok_s) begin
                  gap_y_q     <= sample_s;
                  gap_state_q <= GAP_READY;
                  ready_q     <= 1'b1;
               end else begin
                  gap_state_q <= GAP_SEARCH;
                  ready_q     <= 1'b0;
               end
            end
            default: begin
               gap_state_q <= GAP_READY;
               ready_q     <= 1'b1;
            end
         endcase
      end
   end

   assign oPipe_Wait = wait_q;
   assign oPipe_Gone = gone_q;
   assign oRnd_Ready = ready_q;
   assign oPipe_X    = pipe_x_q;
   assign oGap_Y     = gap_y_q;
   assign oScore     = score_q;

endmodule

// File: tb/tb_pipe_track.sv
// Scoreboard bench for pipe_track with small test parameters.
module tb_pipe_track;

   localparam int X_W     = 10;
   localparam int Y_W     = 5;
   localparam int SCORE_W = 10;
   localparam int X_RESET = 20;
   localparam int GAP_MID = 14;
   localparam int L_INIT  = 3;

   localparam int S_X = 0, S_WAIT = 1, S_GONE = 2, S_RDY = 3, S_GAP = 4, S_SCORE = 5;

   logic               iClk = 1'b0;
   logic               iRst = 1'b1;
   logic               iPipe_Pos_Move = 1'b0;
   logic               iPipe_Pos_Rst = 1'b0;
   logic               iWindow_Shift = 1'b0;
   logic               iPipe_Speed_Inc = 1'b0;
   logic               iScore_Inc = 1'b0;
   logic               oPipe_Wait;
   logic               oPipe_Gone;
   logic               oRnd_Ready;
   logic [X_W-1:0]     oPipe_X;
   logic [Y_W-1:0]     oGap_Y;
   logic [SCORE_W-1:0] oScore;

   pipe_track #(
      .SCREEN_W (16), .PIPE_W (4), .X_W (X_W), .Y_W (Y_W),
      .GAP_MIN (8), .GAP_MAX (20), .DIV_W (20),
      .DIV_INIT (3), .DIV_STEP (1), .DIV_MIN (1), .SCORE_W (SCORE_W)
   ) dut (
      .iClk (iClk), .iRst (iRst),
      .iPipe_Pos_Move (iPipe_Pos_Move), .iPipe_Pos_Rst (iPipe_Pos_Rst),
      .iWindow_Shift (iWindow_Shift), .iPipe_Speed_Inc (iPipe_Speed_Inc),
      .iScore_Inc (iScore_Inc),
      .oPipe_Wait (oPipe_Wait), .oPipe_Gone (oPipe_Gone), .oRnd_Ready (oRnd_Ready),
      .oPipe_X (oPipe_X), .oGap_Y (oGap_Y), .oScore (oScore)
   );

   always #5 iClk = ~iClk;

   int cyc = 0;
   always @(posedge iClk) cyc <= cyc + 1;

   typedef struct {
      int    cyc;
      int    sel;
      int    val;
      string nm;
   } exp_t;

   exp_t  sbq[$];
   int    gapq[$];
   int    checks = 0;
   int    failures = 0;
   bit    mon_en = 1'b0;
   logic  rdy_prev = 1'b1;

   // bench model
   int xm = X_RESET;
   int lm = L_INIT;

   function automatic int actual(input int sel);
      case (sel)
         S_X:     return int'(oPipe_X);
         S_WAIT:  return int'(oPipe_Wait);
         S_GONE:  return int'(oPipe_Gone);
         S_RDY:   return int'(oRnd_Ready);
         S_GAP:   return int'(oGap_Y);
         S_SCORE: return int'(oScore);
         default: return -1;
      endcase
   endfunction

   task automatic push(input int c, input int sel, input int v, input string nm);
      exp_t e;
      e.cyc = c; e.sel = sel; e.val = v; e.nm = nm;
      sbq.push_back(e);
   endtask

   task automatic timeout_fail(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
   endtask

   // monitor: compare timed expectations and every gap commit
   always @(negedge iClk) begin
      if (mon_en) begin
         int i;
         int a;
         i = 0;
         while (i < sbq.size()) begin
            if (sbq[i].cyc <= cyc) begin
               checks++;
               a = actual(sbq[i].sel);
               if (sbq[i].cyc < cyc) begin
                  failures++;
                  $display("FAIL %s: expectation for cycle %0d missed at %0d", sbq[i].nm, sbq[i].cyc, cyc);
               end else if (a != sbq[i].val) begin
                  failures++;
                  $display("FAIL %s @cyc %0d: got %0d expected %0d", sbq[i].nm, cyc, a, sbq[i].val);
               end
               sbq.delete(i);
            end else begin
               i++;
            end
         end
         if (!rdy_prev && oRnd_Ready) begin
            checks++;
            if (gapq.size() == 0) begin
               failures++;
               $display("FAIL gap_commit @cyc %0d: unexpected commit, got gap %0d expected none", cyc, oGap_Y);
            end else begin
               void'(gapq.pop_front());
               if (oGap_Y < 8 || oGap_Y > 20) begin
                  failures++;
                  $display("FAIL gap_range @cyc %0d: got %0d expected 8..20", cyc, oGap_Y);
               end
            end
         end
         rdy_prev = oRnd_Ready;
      end
   end

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (oPipe_Wait && n < 100) begin
         step();
         n++;
      end
      if (oPipe_Wait) timeout_fail("wait_idle");
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!oRnd_Ready && n < 100) begin
         step();
         n++;
      end
      if (!oRnd_Ready) timeout_fail("wait_ready");
   endtask

   task automatic reload_checks(input int c, input int l);
      for (int k = 1; k <= l; k++) push(c + k, S_WAIT, 1, "wait_high");
      push(c + 1 + l, S_WAIT, 0, "wait_fall");
   endtask

   task automatic do_move(input bit with_rst, input bit with_spd);
      int c;
      wait_idle();
      c = cyc;
      if (with_rst) xm = X_RESET;
      else if (xm > 0) xm = xm - 1;
      push(c + 1, S_X, xm, "pipe_x");
      push(c + 1, S_GONE, (xm == 0) ? 1 : 0, "pipe_gone");
      reload_checks(c, lm);
      if (with_spd) lm = (lm >= 1 && lm - 1 >= 1) ? lm - 1 : 1;
      iPipe_Pos_Move = 1'b1;
      iPipe_Pos_Rst = with_rst;
      iPipe_Speed_Inc = with_spd;
      step();
      iPipe_Pos_Move = 1'b0;
      iPipe_Pos_Rst = 1'b0;
      iPipe_Speed_Inc = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      // reset
      repeat (3) step();
      c = cyc;
      mon_en = 1'b1;
      iRst = 1'b0;
      push(c, S_X, X_RESET, "rst_x");
      push(c, S_GONE, 0, "rst_gone");
      push(c, S_RDY, 1, "rst_ready");
      push(c, S_GAP, GAP_MID, "rst_gap");
      push(c, S_SCORE, 0, "rst_score");
      push(c, S_WAIT, 1, "rst_wait");
      push(c + 1, S_WAIT, 1, "rst_wait");
      push(c + 2, S_WAIT, 1, "rst_wait");
      push(c + 3, S_WAIT, 0, "rst_wait_fall");

      // move sweep 20 -> 0, then a move at X==0
      for (int i = 0; i < 20; i++) do_move(1'b0, 1'b0);
      do_move(1'b0, 1'b0);
      // move with pos reset: reset wins
      do_move(1'b1, 1'b0);

      // speed-up together with a reload affects only later reloads
      do_move(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         lm = (lm >= 1 && lm - 1 >= 1) ? lm - 1 : 1;
         iPipe_Speed_Inc = 1'b1;
         step();
         iPipe_Speed_Inc = 1'b0;
      end
      do_move(1'b0, 1'b0);
      do_move(1'b0, 1'b0);

      // score saturation
      c = cyc;
      push(c + 1, S_SCORE, 1, "score_1");
      push(c + 1023, S_SCORE, 1023, "score_1023");
      push(c + 1024, S_SCORE, 1023, "score_sat");
      push(c + 1025, S_SCORE, 1023, "score_hold");
      iScore_Inc = 1'b1;
      repeat (1024) step();
      iScore_Inc = 1'b0;
      step();

      // random gap windows, with a second shift during search
      for (int r = 0; r < 100; r++) begin
         wait_ready();
         c = cyc;
         push(c + 1, S_RDY, 0, "ready_drop");
         gapq.push_back(r);
         iWindow_Shift = 1'b1;
         step();
         step();
         iWindow_Shift = 1'b0;
         while (!oRnd_Ready && (cyc - c) <= 64) step();
         if (!oRnd_Ready) begin
            timeout_fail("gap_search_64");
            wait_ready();
         end
      end

      // reset during a search
      wait_ready();
      c = cyc;
      push(c + 1, S_RDY, 0, "abort_ready_drop");
      gapq.push_back(-1);
      iWindow_Shift = 1'b1;
      step();
      iWindow_Shift = 1'b0;
      iRst = 1'b1;
      push(c + 2, S_RDY, 1, "abort_ready");
      push(c + 2, S_GAP, GAP_MID, "abort_gap");
      push(c + 2, S_SCORE, 0, "abort_score");
      push(c + 2, S_X, X_RESET, "abort_x");
      push(c + 2, S_GONE, 0, "abort_gone");
      push(c + 2, S_WAIT, 1, "abort_wait");
      push(c + 3, S_WAIT, 1, "abort_wait");
      push(c + 4, S_WAIT, 1, "abort_wait");
      push(c + 5, S_WAIT, 0, "abort_wait_fall");
      step();
      iRst = 1'b0;
      xm = X_RESET;
      lm = L_INIT;
      do_move(1'b0, 1'b0);

      repeat (8) step();
      checks++;
      if (sbq.size() != 0 || gapq.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d timed and %0d gap entries pending, expected 0 and 0", sbq.size(), gapq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
